// File: rtl/button_debouncer_pkg.sv
// -----------------------------------------------------------------------------
// button_debouncer_pkg
// Shared definitions for the push-button conditioning path and its consumers
// (for example the blink stage). It holds the press-classifier state encoding,
// the default timing constants and a helper that sizes timing counters.
// -----------------------------------------------------------------------------
package button_debouncer_pkg;

  // Press classifier states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } btn_state_e;

  // Default cycle counts at a 50 MHz board clock: 100 us debounce window,
  // 1 ms long-press threshold.
  localparam int unsigned DEF_DEBOUNCE_CYCLES   = 5000;
  localparam int unsigned DEF_LONG_PRESS_CYCLES = 50000;

  // DE-board KEYs read 0 while pressed.
  localparam bit DEF_KEY_ACTIVE_LOW = 1'b1;

  // Width of a counter that must be able to hold the value 'cycles'.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/button_debouncer_sync_debounce.sv
// -----------------------------------------------------------------------------
// button_debouncer_sync_debounce
// Brings an asynchronous button or switch pin into the clock domain and
// debounces it. A level change is accepted only after DEBOUNCE_CYCLES
// consecutive synchronised samples disagree with the current debounced level.
// The module can be reused for the board's other KEY and SW inputs.
//
// Ports
//   clk_i    : clock, all logic on the rising edge
//   rst_i    : synchronous active-high reset
//   raw_i    : asynchronous raw pin
//   level_o  : debounced level, 1 = pressed/active (registered)
//   flip_o   : high in the cycle before level_o toggles (combinational), so
//              the parent can register edge pulses that line up with level_o
// -----------------------------------------------------------------------------
module button_debouncer_sync_debounce
  import button_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW      = DEF_KEY_ACTIVE_LOW
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic flip_o
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Reset value of the synchroniser is the not-pressed pin level, so a key
  // still held when reset releases is seen as a fresh press.
  localparam logic IDLE_PIN = ACTIVE_LOW ? 1'b1 : 1'b0;

  logic          sync1_q;
  logic          sync2_q;
  logic          key_s;
  logic          mismatch;
  logic          flip;
  logic [CW-1:0] deb_cnt_q;
  logic [CW-1:0] deb_cnt_d;
  logic          level_q;
  logic          level_d;

  // Polarity correction: key_s is 1 while the button is pressed.
  assign key_s = ACTIVE_LOW ? ~sync2_q : sync2_q;

  always_comb begin
    mismatch  = (key_s != level_q);
    flip      = mismatch && (deb_cnt_q == CNT_LAST);
    // Any agreeing sample restarts the window, so bounces of any length are
    // discarded; the count also clears on the accepting edge.
    deb_cnt_d = '0;
    if (mismatch && !flip) begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end
    level_d = flip ? ~level_q : level_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q   <= IDLE_PIN;
      sync2_q   <= IDLE_PIN;
      deb_cnt_q <= '0;
      level_q   <= 1'b0;
    end else begin
      sync1_q   <= raw_i;
      sync2_q   <= sync1_q;
      deb_cnt_q <= deb_cnt_d;
      level_q   <= level_d;
    end
  end

  assign level_o = level_q;
  assign flip_o  = flip;

endmodule

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
// Turns a raw mechanical push-button into clean single-cycle events for the
// LED blink stage. A tap (press released before the long-press threshold)
// yields short_release, which drives the blinker's reset input.
//
// State table
//   state      | meaning
//   ST_IDLE    | button released (btn_level = 0)
//   ST_PRESSED | debounced press, hold_cnt counting toward long press
//   ST_HELD    | long press already reported, waiting for release
//
// Ports
//   CLOCK_50      : board clock, all logic on the rising edge
//   reset         : synchronous active-high reset
//   key_raw       : asynchronous raw button pin
//   btn_level     : debounced level, 1 = pressed
//   press_pulse   : one cycle, first cycle btn_level shows 1
//   release_pulse : one cycle, first cycle btn_level shows 0
//   long_pulse    : one cycle, LONG_PRESS_CYCLES cycles after press_pulse
//   short_release : one cycle, with release_pulse when no long_pulse occurred
// -----------------------------------------------------------------------------
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter bit          KEY_ACTIVE_LOW    = DEF_KEY_ACTIVE_LOW
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic key_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic short_release
);

  localparam int unsigned HW = cnt_width(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

  logic          deb_level;
  logic          deb_flip;
  logic          deb_press;
  logic          deb_release;

  btn_state_e    state_q;
  logic [HW-1:0] hold_cnt_q;
  logic          press_q;
  logic          release_q;
  logic          long_q;
  logic          short_q;

  button_debouncer_sync_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .ACTIVE_LOW      (KEY_ACTIVE_LOW)
  ) u_sync_debounce (
    .clk_i   (CLOCK_50),
    .rst_i   (reset),
    .raw_i   (key_raw),
    .level_o (deb_level),
    .flip_o  (deb_flip)
  );

  // The debounced level changes at the next edge; registering the pulses on
  // that same edge makes them coincide with the new btn_level.
  assign deb_press   = deb_flip && !deb_level;
  assign deb_release = deb_flip &&  deb_level;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      short_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (deb_press) begin
            press_q    <= 1'b1;
            hold_cnt_q <= '0;
            state_q    <= ST_PRESSED;
          end
        end
        ST_PRESSED: begin
          // Release is checked first so a release landing on the threshold
          // cycle is reported as a tap rather than a long press.
          if (deb_release) begin
            release_q <= 1'b1;
            short_q   <= 1'b1;
            state_q   <= ST_IDLE;
          end else if (hold_cnt_q == HOLD_LAST) begin
            long_q  <= 1'b1;
            state_q <= ST_HELD;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        ST_HELD: begin
          // hold_cnt stays frozen here; it never wraps.
          if (deb_release) begin
            release_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign btn_level     = deb_level;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign short_release = short_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20,
// KEY_ACTIVE_LOW=1. A behavioural model derives the expected outputs for every
// clock edge from the input history; directed scenarios then pin event timing
// with literal latencies, followed by randomized key activity and resets.
module tb_button_debouncer;

  localparam int D  = 4;
  localparam int L  = 20;
  localparam bit AL = 1'b1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic key_raw = 1'b0;
  logic btn_level, press_pulse, release_pulse, long_pulse, short_release;

  always #5 clk = ~clk;

  button_debouncer #(
    .DEBOUNCE_CYCLES   (D),
    .LONG_PRESS_CYCLES (L),
    .KEY_ACTIVE_LOW    (AL)
  ) dut (
    .CLOCK_50      (clk),
    .reset         (reset),
    .key_raw       (key_raw),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .short_release (short_release)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  // n is the index of the most recent rising edge.
  int n = -1;
  bit raw_h [16];
  bit rst_h [16];
  bit ks_h  [16];
  bit m_level, m_press, m_rel, m_long, m_short;
  bit m_long_done;
  int m_press_edge;

  function automatic bit pressed_of(input bit r);
    return AL ? !r : r;
  endfunction

  always @(posedge clk) begin : model
    bit flip;
    n = n + 1;
    raw_h[n % 16] = key_raw;
    rst_h[n % 16] = reset;
    // The pressed state seen at edge n is the pin sampled two edges earlier,
    // forced to not-pressed if either intervening edge was in reset.
    ks_h[n % 16] = (n >= 2) && !rst_h[(n - 1) % 16] && !rst_h[(n - 2) % 16]
                   && pressed_of(raw_h[(n - 2) % 16]);
    m_press = 0; m_rel = 0; m_long = 0; m_short = 0;
    if (reset) begin
      m_level     = 0;
      m_long_done = 0;
    end else begin
      // Level changes once the last D non-reset edges all disagreed with it.
      flip = 1;
      for (int j = n - D + 1; j <= n; j++) begin
        if (j < 0 || rst_h[j % 16] || ks_h[j % 16] == m_level) flip = 0;
      end
      if (flip && !m_level) begin
        m_level = 1; m_press = 1; m_press_edge = n; m_long_done = 0;
      end else if (flip && m_level) begin
        m_level = 0; m_rel = 1; m_short = !m_long_done;
      end else if (m_level && !m_long_done && n == m_press_edge + L) begin
        m_long = 1; m_long_done = 1;
      end
    end
  end

  // ---------------- per-cycle compare and event log ----------------
  int dut_press_at = -1, dut_rel_at = -1, dut_long_at = -1, dut_short_at = -1;
  int press_cnt = 0, long_cnt = 0, short_cnt = 0;

  always @(posedge clk) begin : compare
    logic [4:0] got, want;
    #1;
    got  = {btn_level, press_pulse, release_pulse, long_pulse, short_release};
    want = {m_level, m_press, m_rel, m_long, m_short};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL outputs edge %0d {lvl,prs,rel,lng,sht} got %b want %b", n, got, want);
    end
    if (press_pulse === 1'b1)   begin dut_press_at = n; press_cnt++; end
    if (release_pulse === 1'b1) dut_rel_at = n;
    if (long_pulse === 1'b1)    begin dut_long_at = n; long_cnt++; end
    if (short_release === 1'b1) begin dut_short_at = n; short_cnt++; end
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic check_eq(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  int t0, t1, pc, lc, sc;

  initial begin
    // 1: reset with the key held, then fresh press after reset
    reset = 1'b1; key_raw = 1'b0;
    cyc(2);
    check_eq("reset btn_level", int'(btn_level), 0);
    check_eq("reset pulses", int'({press_pulse, release_pulse, long_pulse, short_release}), 0);
    reset = 1'b0; t0 = n;
    cyc(8);
    check_eq("t1 press latency", dut_press_at - t0, 6);
    key_raw = 1'b1; t0 = n;
    cyc(10);
    check_eq("t1 release latency", dut_rel_at - t0, 6);
    check_eq("t1 short latency", dut_short_at - t0, 6);

    // 2: clean tap
    cyc(5);
    lc = long_cnt;
    key_raw = 1'b0; t0 = n;
    cyc(10);
    key_raw = 1'b1; t1 = n;
    cyc(10);
    check_eq("t2 press latency", dut_press_at - t0, 6);
    check_eq("t2 release latency", dut_rel_at - t1, 6);
    check_eq("t2 short with release", dut_short_at - t1, 6);
    check_eq("t2 no long", long_cnt - lc, 0);

    // 3: bounce shorter than the debounce window
    pc = press_cnt;
    key_raw = 1'b0; cyc(1);
    key_raw = 1'b1; cyc(1);
    key_raw = 1'b0; cyc(1);
    cyc(2);
    key_raw = 1'b1;
    cyc(12);
    check_eq("t3 no press", press_cnt - pc, 0);
    check_eq("t3 level low", int'(btn_level), 0);

    // 4: long press
    sc = short_cnt;
    key_raw = 1'b0; t0 = n;
    cyc(40);
    key_raw = 1'b1; t1 = n;
    cyc(10);
    check_eq("t4 press latency", dut_press_at - t0, 6);
    check_eq("t4 long after press", dut_long_at - dut_press_at, 20);
    check_eq("t4 release latency", dut_rel_at - t1, 6);
    check_eq("t4 no short", short_cnt - sc, 0);

    // 5: release lands on the long threshold
    lc = long_cnt;
    key_raw = 1'b0; t0 = n;
    cyc(20);
    key_raw = 1'b1;
    cyc(12);
    check_eq("t5 no long", long_cnt - lc, 0);
    check_eq("t5 release at threshold", dut_rel_at - dut_press_at, 20);
    check_eq("t5 short with release", dut_short_at, dut_rel_at);

    // 6: reset while held, key still down
    key_raw = 1'b0;
    cyc(30);
    reset = 1'b1;
    cyc(2);
    check_eq("t6 reset btn_level", int'(btn_level), 0);
    check_eq("t6 reset pulses", int'({press_pulse, release_pulse, long_pulse, short_release}), 0);
    reset = 1'b0; t0 = n;
    cyc(30);
    check_eq("t6 press latency", dut_press_at - t0, 6);
    check_eq("t6 long after press", dut_long_at - dut_press_at, 20);
    key_raw = 1'b1;
    cyc(10);

    // random activity: runs of 1..30 cycles with occasional resets
    repeat (120) begin
      key_raw = 1'($urandom_range(0, 1));
      cyc($urandom_range(1, 30));
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        cyc($urandom_range(1, 3));
        reset = 1'b0;
      end
    end
    key_raw = 1'b1;
    cyc(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
